// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with wait-stated data memory and freeze; MEM_STAGE_ADDR_CHECK_EN enables range checking
module mem_stage #(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WB_EN_in,
    input  logic                 MEM_R_EN_in,
    input  logic                 MEM_W_EN_in,
    input  logic [4:0]           dest_in,
    input  logic [WORD_SIZE-1:0] ALU_res_in,
    input  logic [WORD_SIZE-1:0] ST_value_in,
    output logic [WORD_SIZE-1:0] ALU_res_MEM,
    output logic                 freeze,
    output logic                 WB_EN_out,
    output logic                 MEM_R_EN_out,
    output logic [4:0]           dest_out,
    output logic [WORD_SIZE-1:0] ALU_res_out,
    output logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 addr_err
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 req, load, oor;
    logic [ADDR_W-1:0]    idx;
    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
    logic                 unused_bits;

    assign req = MEM_R_EN_in | MEM_W_EN_in;
    assign idx = ALU_res_in[ADDR_W+1:2];
    assign ALU_res_MEM = ALU_res_in;

`ifdef MEM_STAGE_ADDR_CHECK_EN
    assign oor = |ALU_res_in[WORD_SIZE-1:ADDR_W+2];
    assign unused_bits = ^ALU_res_in[1:0];
    always_ff @(posedge clk)
        addr_err <= rst ? 1'b0 : addr_err | (load & req & oor);
`else
    assign oor = 1'b0;
    assign unused_bits = ^{ALU_res_in[WORD_SIZE-1:ADDR_W+2], ALU_res_in[1:0]};
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        freeze = 1'b0;
        load = 1'b0;
        if (state == IDLE) begin
            if (req && WAIT_CYCLES > 0) begin
                freeze = 1'b1;
                state_nx = WAIT;
                cnt_nx = CNT_W'(1);
            end else begin
                load = 1'b1;
            end
        end else if (cnt < CNT_MAX) begin
            freeze = 1'b1;
            cnt_nx = cnt + 1'b1;
        end else begin
            load = 1'b1;
            state_nx = IDLE;
            cnt_nx = '0;
        end
        if (rst) freeze = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            WB_EN_out <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            dest_out <= '0;
            ALU_res_out <= '0;
            mem_data_out <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (load) begin
                WB_EN_out <= WB_EN_in;
                MEM_R_EN_out <= MEM_R_EN_in;
                dest_out <= dest_in;
                ALU_res_out <= ALU_res_in;
                mem_data_out <= (MEM_R_EN_in && !MEM_W_EN_in && !oor) ? mem[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && load && MEM_W_EN_in && !oor) mem[idx] <= ST_value_in;
endmodule
